ov7670_capture_ctrl: RTL and testbench

//  Parametrised OV7670 capture front-end: frames byte pairs from the camera's

---
 rtl/ov7670_capture_ctrl_pkg.sv | 34 +++
 rtl/ov7670_capture_ctrl_if.sv | 13 +
 rtl/ov7670_capture_ctrl_gray.sv | 32 +++
 rtl/ov7670_capture_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_ov7670_capture_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_capture_ctrl_pkg.sv
// Shared types and constants for the OV7670 capture front-end.
package ov7670_cap_pkg;

  // Capture FSM states, also exported on the debug port of the top.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    END     = 2'd3
  } cap_state_t;

  // The camera sends every pixel as two bytes, high byte first.
  localparam int BYTES_PER_PIX = 2;

  // BT.601-style luma weights scaled by 256.
  localparam logic [15:0] LUMA_R = 16'd77;
  localparam logic [15:0] LUMA_G = 16'd150;
  localparam logic [15:0] LUMA_B = 16'd29;

  // Expands RGB565 to 8 bits per channel by bit replication and returns
  // the weighted sum divided by 256. The sum never exceeds 16 bits.
  function automatic logic [7:0] luma8(input logic [15:0] rgb);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r8  = {rgb[15:11], rgb[15:13]};
    g8  = {rgb[10:5], rgb[10:9]};
    b8  = {rgb[4:0], rgb[4:2]};
    sum = LUMA_R * {8'h00, r8} + LUMA_G * {8'h00, g8} + LUMA_B * {8'h00, b8};
    return sum[15:8];
  endfunction

endpackage

// File: rtl/ov7670_capture_ctrl_if.sv
// Frame-buffer write port between the capture controller and the RAM.
// Handshake: we is a one-cycle strobe qualifying wAddr/wData in that same
// cycle; there is no ready/backpressure, the RAM accepts every write.
interface ov7670_capture_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [15:0]       wData;

  modport master (output we, wAddr, wData);
  modport slave  (input  we, wAddr, wData);
endinterface

// File: rtl/ov7670_capture_ctrl_gray.sv
// One-stage output register: converts RGB565 to Gray8 when gray_mode is set,
// otherwise passes the pixel through with the same one-cycle delay.
module rgb565_to_gray
  import ov7670_cap_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              gray_mode,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [15:0]       in_pix,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_data
);

  // Register strobe, address and (optionally converted) pixel together.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_addr  <= in_addr;
      out_data  <= gray_mode ? {8'h00, luma8(in_pix)} : in_pix;
    end
  end

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 capture front-end: frames href/v_sync byte pairs into pixels and
// writes them to a (optionally ping-pong) frame buffer, with line/frame
// length checking and frame-done signalling.
module ov7670_capture_ctrl
  import ov7670_cap_pkg::*;
#(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int BANKS  = 1,
  parameter int ADDR_W = 17
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       cap_en,
  input  logic       single_shot,
  input  logic       gray_mode,
  input  logic       href,
  input  logic       v_sync,
  input  logic [7:0] ov7670_data,
  ov7670_capture_ctrl_if.master wr_if,
  output logic       wr_bank,
  output logic       rd_bank,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       err_line_len,
  output logic       err_frame_len,
  output logic       busy,
  output cap_state_t state_dbg
);

  localparam logic [15:0]       LINE_BYTES  = 16'(BYTES_PER_PIX * H_RES);
  localparam logic [15:0]       H_LIM       = 16'(H_RES);
  localparam logic [9:0]        V_LIM       = 10'(V_RES);
  localparam logic [ADDR_W-1:0] BANK_STRIDE = ADDR_W'(H_RES * V_RES);

  cap_state_t        state;
  logic              shot_done;
  logic              gray_lat;

  logic              href_r, href_rr, vs_r, vs_rr;
  logic [7:0]        data_r;
  logic              href_rise, href_fall, vs_rise, vs_fall;
  logic              enter_active;

  logic [15:0]       byte_cnt;
  logic [9:0]        line_cnt;
  logic [7:0]        hi_byte;
  logic [15:0]       byte_idx;
  logic [15:0]       byte_next;
  logic [15:0]       pix_idx;
  logic [9:0]        line_inc;
  logic              pix_in_frame;
  logic              frame_good;
  logic [ADDR_W-1:0] wr_addr_c;

  logic              pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic [15:0]       pix_data;

  assign state_dbg = state;

  // Register the camera pins; all edge detection works on these copies.
  // v_sync resets low so that a capture can only start on a genuine fall.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      href_r  <= 1'b0;
      href_rr <= 1'b0;
      vs_r    <= 1'b0;
      vs_rr   <= 1'b0;
      data_r  <= '0;
    end else begin
      href_r  <= href;
      href_rr <= href_r;
      vs_r    <= v_sync;
      vs_rr   <= vs_r;
      data_r  <= ov7670_data;
    end
  end

  assign href_rise    = href_r & ~href_rr;
  assign href_fall    = ~href_r & href_rr;
  assign vs_rise      = vs_r & ~vs_rr;
  assign vs_fall      = ~vs_r & vs_rr;
  assign enter_active = (state == WAIT_VS) && vs_fall;

  // Byte position within the line, pixel position and its frame-buffer address.
  always_comb begin
    byte_idx     = href_rise ? 16'd0 : byte_cnt;
    byte_next    = (byte_idx == 16'hFFFF) ? byte_idx : byte_idx + 16'd1;
    pix_idx      = byte_idx >> 1;
    line_inc     = (line_cnt == 10'd1023) ? line_cnt : line_cnt + 10'd1;
    pix_in_frame = (pix_idx < H_LIM) && (line_cnt < V_LIM);
    frame_good   = (line_cnt == V_LIM) && !err_line_len;
    wr_addr_c    = (wr_bank ? BANK_STRIDE : '0)
                 + ADDR_W'(line_cnt) * ADDR_W'(H_RES)
                 + ADDR_W'(pix_idx);
  end

  // Line datapath: byte pairing, clipping, line counting and line-length check.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt     <= '0;
      line_cnt     <= '0;
      hi_byte      <= '0;
      err_line_len <= 1'b0;
      pix_valid    <= 1'b0;
      pix_addr     <= '0;
      pix_data     <= '0;
    end else begin
      pix_valid <= 1'b0;
      if (enter_active) begin
        byte_cnt     <= '0;
        line_cnt     <= '0;
        err_line_len <= 1'b0;
      end else if (state == ACTIVE) begin
        if (vs_rise) begin
          // Frame ends with a line still open: close it, drop any half pixel.
          if (href_rr) begin
            if (byte_cnt != LINE_BYTES) err_line_len <= 1'b1;
            line_cnt <= line_inc;
          end
        end else begin
          if (href_r) begin
            byte_cnt <= byte_next;
            if (!byte_idx[0]) begin
              hi_byte <= data_r;
            end else if (pix_in_frame) begin
              pix_valid <= 1'b1;
              pix_addr  <= wr_addr_c;
              pix_data  <= {hi_byte, data_r};
            end
          end
          if (href_fall) begin
            if (byte_cnt != LINE_BYTES) err_line_len <= 1'b1;
            line_cnt <= line_inc;
          end
        end
      end
    end
  end

  // Capture FSM with registered status outputs and bank bookkeeping.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      shot_done     <= 1'b0;
      gray_lat      <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      err_frame_len <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A finished single shot re-arms only once it is released.
      if (!cap_en || !single_shot) shot_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cap_en && !shot_done) begin
            state <= WAIT_VS;
            busy  <= 1'b1;
          end
        end
        WAIT_VS: begin
          if (vs_fall) begin
            state         <= ACTIVE;
            gray_lat      <= gray_mode;
            err_frame_len <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            state <= END;
            busy  <= 1'b0;
          end
        end
        END: begin
          frame_done <= 1'b1;
          if (frame_good) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (BANKS == 2) begin
              rd_bank <= wr_bank;
              wr_bank <= ~wr_bank;
            end
          end
          if (line_cnt != V_LIM) err_frame_len <= 1'b1;
          if ((single_shot && frame_good) || !cap_en) begin
            state     <= IDLE;
            busy      <= 1'b0;
            shot_done <= single_shot && frame_good && cap_en;
          end else begin
            state <= WAIT_VS;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [15:0]       out_data;

  rgb565_to_gray #(.ADDR_W(ADDR_W)) u_gray (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .gray_mode (gray_lat),
    .in_valid  (pix_valid),
    .in_addr   (pix_addr),
    .in_pix    (pix_data),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data)
  );

  assign wr_if.we    = out_valid;
  assign wr_if.wAddr = out_addr;
  assign wr_if.wData = out_data;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed/randomized bench for ov7670_capture_ctrl on a small 8x4 ping-pong
// frame buffer; expected writes come from a frame-level reference model.
module tb_ov7670_capture_ctrl;
  import ov7670_cap_pkg::*;

  localparam int H      = 8;
  localparam int V      = 4;
  localparam int ADDR_W = 7;

  // ---------------- clock / reset / DUT ----------------
  logic       pclk = 1'b0;
  logic       reset_n, cap_en, single_shot, gray_mode, href, v_sync;
  logic [7:0] ov7670_data;
  logic       wr_bank, rd_bank, frame_done, err_line_len, err_frame_len, busy;
  logic [7:0] frame_cnt;
  cap_state_t state_dbg;
  int         cyc = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  ov7670_capture_ctrl_if #(.ADDR_W(ADDR_W)) wr_if ();

  ov7670_capture_ctrl #(.H_RES(H), .V_RES(V), .BANKS(2), .ADDR_W(ADDR_W)) dut (
    .pclk          (pclk),
    .reset_n       (reset_n),
    .cap_en        (cap_en),
    .single_shot   (single_shot),
    .gray_mode     (gray_mode),
    .href          (href),
    .v_sync        (v_sync),
    .ov7670_data   (ov7670_data),
    .wr_if         (wr_if),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .err_line_len  (err_line_len),
    .err_frame_len (err_frame_len),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  logic [63:0] exp_q[$];   // {due cycle, addr at [16 +: ADDR_W], data}
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          n_lines;
  int          line_len[16];
  logic [7:0]  line_bytes[16][32];
  bit          m_wr, m_rd, m_err_line, m_err_frame;
  int          m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int c, input logic [ADDR_W-1:0] a,
                                       input logic [15:0] d);
    logic [63:0] e;
    e             = '0;
    e[63:32]      = c;
    e[16+:ADDR_W] = a;
    e[15:0]       = d;
    return e;
  endfunction

  // Reference pixel value: plain arithmetic on the channel fields.
  function automatic logic [15:0] model_pix(input logic [7:0] hi, input logic [7:0] lo,
                                            input bit gray);
    int r, g, b, y;
    if (!gray) return {hi, lo};
    r = int'(hi[7:3]);
    g = int'(hi[2:0]) * 8 + int'(lo[7:5]);
    b = int'(lo[4:0]);
    y = (77 * (r * 8 + r / 4) + 150 * (g * 4 + g / 16) + 29 * (b * 8 + b / 4)) / 256;
    return {8'h00, 8'(y)};
  endfunction

  // One pclk: wait for the falling edge, then check the write port.
  task automatic tick();
    @(negedge pclk);
    if (frame_done) done_cnt++;
    if (wr_if.we) begin
      check("write_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0)
        check("write", pack(cyc, wr_if.wAddr, wr_if.wData), exp_q.pop_front());
    end else if (exp_q.size() != 0 && int'(exp_q[0][63:32]) < cyc) begin
      check("write_missed_cycle", 64'(cyc), {32'd0, exp_q[0][63:32]});
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_status(input string pfx);
    check({pfx, "_frame_cnt"}, 64'(frame_cnt), 64'(m_cnt));
    check({pfx, "_wr_bank"}, 64'(wr_bank), 64'(m_wr));
    check({pfx, "_rd_bank"}, 64'(rd_bank), 64'(m_rd));
    check({pfx, "_err_line"}, 64'(err_line_len), 64'(m_err_line));
    check({pfx, "_err_frame"}, 64'(err_frame_len), 64'(m_err_frame));
  endtask

  task automatic set_lines(input int n, input int len, input bit ramp);
    n_lines = n;
    for (int l = 0; l < 16; l++) begin
      line_len[l] = len;
      for (int b = 0; b < 32; b++)
        line_bytes[l][b] = ramp ? 8'(l * len + b) : 8'($urandom_range(0, 255));
    end
  endtask

  // Drives one complete frame; cap says whether the DUT should capture it.
  task automatic send_frame(input string pfx, input bit cap);
    int  snap;
    int  base;
    bit  bad_line;
    bit  good;
    snap = done_cnt;
    base = m_wr ? H * V : 0;
    tick(); v_sync = 1'b1; href = 1'b0;
    repeat (4) tick();
    v_sync = 1'b0;
    repeat (4) tick();
    if (cap) begin
      check({pfx, "_entry_err_line"}, 64'(err_line_len), 64'd0);
      check({pfx, "_entry_err_frame"}, 64'(err_frame_len), 64'd0);
      check({pfx, "_entry_busy"}, 64'(busy), 64'd1);
    end else begin
      check({pfx, "_idle_busy"}, 64'(busy), 64'd0);
    end
    for (int l = 0; l < n_lines; l++) begin
      for (int b = 0; b < line_len[l]; b++) begin
        href = 1'b1;
        ov7670_data = line_bytes[l][b];
        if (cap && b[0] && (b / 2) < H && l < V)
          exp_q.push_back(pack(cyc + 3, ADDR_W'(base + l * H + b / 2),
                               model_pix(line_bytes[l][b-1], line_bytes[l][b], gray_mode)));
        tick();
      end
      href = 1'b0;
      repeat (3) tick();
    end
    v_sync = 1'b1;
    repeat (6) tick();
    good = 1'b0;
    if (cap) begin
      bad_line = 1'b0;
      for (int l = 0; l < n_lines; l++) if (line_len[l] != 2 * H) bad_line = 1'b1;
      good        = (n_lines == V) && !bad_line;
      m_err_line  = bad_line;
      m_err_frame = (n_lines != V);
      if (good) begin
        m_cnt = (m_cnt + 1) % 256;
        m_rd  = m_wr;
        m_wr  = ~m_wr;
      end
    end
    check({pfx, "_frame_done"}, 64'(done_cnt - snap), 64'(cap ? 1 : 0));
    check({pfx, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check_status(pfx);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; cap_en = 1'b0; single_shot = 1'b0; gray_mode = 1'b0;
    href = 1'b0; v_sync = 1'b1; ov7670_data = 8'h00;
    m_wr = 1'b0; m_rd = 1'b0; m_cnt = 0; m_err_line = 1'b0; m_err_frame = 1'b0;
    repeat (3) tick();
    check("rst_we", 64'(wr_if.we), 64'd0);
    check("rst_addr", 64'(wr_if.wAddr), 64'd0);
    check("rst_data", 64'(wr_if.wData), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    check_status("rst");
    reset_n = 1'b1;
    tick();
    cap_en = 1'b1;
    repeat (2) tick();
    check("arm_state", 64'(state_dbg), 64'(WAIT_VS));

    // Continuous RGB565 ramp frame, then two random frames (ping-pong bases).
    set_lines(V, 2 * H, 1'b1); send_frame("ramp", 1'b1);
    check("cont_busy", 64'(busy), 64'd1);
    set_lines(V, 2 * H, 1'b0); send_frame("rand1", 1'b1);
    // Gray frame with the corner-case pixels at the start of line 0.
    set_lines(V, 2 * H, 1'b0);
    line_bytes[0][0] = 8'hFF; line_bytes[0][1] = 8'hFF;
    line_bytes[0][2] = 8'hF8; line_bytes[0][3] = 8'h00;
    line_bytes[0][4] = 8'h00; line_bytes[0][5] = 8'h00;
    gray_mode = 1'b1;
    send_frame("gray", 1'b1);
    gray_mode = 1'b0;

    // Overlong line (clipped) and short line.
    set_lines(V, 2 * H, 1'b0); line_len[0] = 2 * H + 2; line_len[1] = 2 * H - 2;
    send_frame("linelen", 1'b1);
    // Odd byte count: the trailing half pixel is never written.
    set_lines(V, 2 * H, 1'b0); line_len[2] = 2 * H - 1;
    send_frame("oddlen", 1'b1);
    // Short frame, then overrun frame (extra line clipped).
    set_lines(V - 1, 2 * H, 1'b0); send_frame("short", 1'b1);
    set_lines(V + 1, 2 * H, 1'b0); send_frame("long", 1'b1);
    // Good frame clears the flags again.
    set_lines(V, 2 * H, 1'b0); send_frame("recover", 1'b1);

    // Single shot: one good frame, then the DUT stays idle.
    single_shot = 1'b1;
    set_lines(V, 2 * H, 1'b0); send_frame("shot", 1'b1);
    check("shot_state", 64'(state_dbg), 64'(IDLE));
    set_lines(V, 2 * H, 1'b0); send_frame("shot_idle", 1'b0);
    check("shot_idle_state", 64'(state_dbg), 64'(IDLE));
    cap_en = 1'b0; single_shot = 1'b0;
    repeat (2) tick();
    cap_en = 1'b1;
    repeat (2) tick();

    // Reset pulsed in the middle of a line.
    v_sync = 1'b0;
    repeat (4) tick();
    set_lines(V, 2 * H, 1'b0);
    for (int b = 0; b < 5; b++) begin
      href = 1'b1;
      ov7670_data = line_bytes[0][b];
      if (b[0])
        exp_q.push_back(pack(cyc + 3, ADDR_W'((m_wr ? H * V : 0) + b / 2),
                             model_pix(line_bytes[0][b-1], line_bytes[0][b], 1'b0)));
      tick();
    end
    #2 reset_n = 1'b0;
    exp_q.delete();
    m_wr = 1'b0; m_rd = 1'b0; m_cnt = 0; m_err_line = 1'b0; m_err_frame = 1'b0;
    #1;
    check("mid_rst_we", 64'(wr_if.we), 64'd0);
    check("mid_rst_data", 64'(wr_if.wData), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_state", 64'(state_dbg), 64'(IDLE));
    check_status("mid_rst");
    tick();
    #2 reset_n = 1'b1;
    // Rest of the interrupted frame: must produce no writes.
    for (int b = 5; b < 2 * H; b++) begin
      ov7670_data = line_bytes[0][b];
      tick();
    end
    href = 1'b0;
    repeat (3) tick();
    for (int b = 0; b < 2 * H; b++) begin
      href = 1'b1;
      ov7670_data = line_bytes[1][b];
      tick();
    end
    href = 1'b0;
    repeat (3) tick();
    check("post_rst_wait_state", 64'(state_dbg), 64'(WAIT_VS));
    check("post_rst_no_done", 64'(frame_done), 64'd0);
    set_lines(V, 2 * H, 1'b0); send_frame("post_rst", 1'b1);

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
